regfile_mp_sb: RTL
==================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the in-order pipeline core.
- Provides NRD combinational read ports, two write-back ports (ALU and load) and optional write-to-read bypass.
- Includes a per-register busy scoreboard that decode uses to detect RAW hazards against in-flight instructions.
- Replaces the single-write-port, two-read-port, scoreboard-less register file.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; x0 is hardwired zero.
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, 1 means a same-cycle write is visible on read ports; 0 means reads return stored value only.
- AW, $clog2(NREG), register index width (derived, not overridden).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- rs_i  in  NRD*AW  read indices; port k uses bits [k*AW +: AW].
- op_o  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- busy_o  out  NRD  port k high when register rs_i[k] is marked busy.
- we0_i  in  1  write port 0 enable (ALU write-back).
- rd0_i  in  AW  write port 0 index.
- wd0_i  in  XLEN  write port 0 data.
- we1_i  in  1  write port 1 enable (load write-back).
- rd1_i  in  AW  write port 1 index.
- wd1_i  in  XLEN  write port 1 data.
- iss_i  in  1  issue strobe; marks iss_rd_i busy.
- iss_rd_i  in  AW  destination of issuing instruction.
- any_busy_o  out  1  OR of all busy bits (drain/fence indicator).

Behaviour:
- Reset (rst_ni low, asynchronous): all registers = 0, all busy bits = 0. Hence op_o = 0, busy_o = 0, any_busy_o = 0 while in reset and after release.
- Write: on posedge, if weN_i and rdN_i != 0, then reg[rdN_i] <= wdN_i. Writes to index 0 are ignored.
- Indices >= NREG are ignored on write. On read they return 0 with busy 0.
- Dual-write conflict (we0_i && we1_i && rd0_i == rd1_i != 0): port 1 wins. Port 0 data is dropped.
- Read is combinational, zero latency. rs_i[k] == 0 always gives op_o = 0 and busy_o[k] = 0.
- Bypass (BYPASS=1): if weN_i and rdN_i == rs_i[k] != 0, op_o[k] = wdN_i in the same cycle. Port 1 takes priority over port 0, consistent with the write-conflict rule.
- BYPASS=0: op_o reflects the stored value; the new value appears the cycle after the write edge.
- Scoreboard, per register r != 0, on posedge:
  - set when iss_i && iss_rd_i == r;
  - clear when (we0_i && rd0_i == r) or (we1_i && rd1_i == r);
  - set and clear of the same r in one cycle: set wins, so busy stays 1 for the newly issued producer.
- busy_o[k] is combinational from the stored busy bits. It does not include same-cycle clears; decode stalls one extra cycle only when BYPASS=0. With BYPASS=1, busy_o[k] is masked to 0 when a same-cycle write targets rs_i[k] and no same-cycle issue to that register is pending.
- iss_i with iss_rd_i == 0 has no effect.
- Write without prior issue: data is written and busy remains 0. This is legal for CSR and debug writes.
- Reset mid-operation: all in-flight busy bits are lost. The pipeline flushes concurrently.
- No X propagation: unwritten registers read 0.

Test Plan:
- Reset: hold rst_ni=0 with random inputs, then release → all 32 reads return 0, busy_o=0, any_busy_o=0.
- Basic write/read: we0 rd0=5 wd0=0xDEADBEEF, next cycle rs_i[0]=5 → op_o[0]=0xDEADBEEF. Write rd0=0 value 0x1234 → reading x0 gives 0.
- Bypass and conflict (BYPASS=1):
  - Same cycle we0 rd0=7 wd0=0x11 and we1 rd1=7 wd1=0x22, with rs_i[1]=7 → op_o[1]=0x22 in that cycle.
  - Next cycle x7 reads 0x22.
  - Repeat with BYPASS=0 → old value, then 0x22 one cycle later.
- Scoreboard:
  - iss_i rd=3 → busy_o for rs=3 is 1 next cycle and any_busy_o=1.
  - we1 rd1=3 → busy clears after the edge (masked same cycle when BYPASS=1).
- Set/clear collision: x9 busy, same cycle we0 rd0=9 and iss_i rd=9 → x9 stays busy, data updated. A later write to 9 clears it.
- Async reset mid-flight: x4 busy with value 0x55, pulse rst_ni low between clock edges → busy and data clear immediately without a clock edge.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with two write-back ports, optional write-to-read
// bypass and a per-register busy scoreboard for RAW hazard detection in decode.
module regfile_mp_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NRD*AW-1:0]   rs_i,
    output logic [NRD*XLEN-1:0] op_o,
    output logic [NRD-1:0]      busy_o,
    input  logic                we0_i,
    input  logic [AW-1:0]       rd0_i,
    input  logic [XLEN-1:0]     wd0_i,
    input  logic                we1_i,
    input  logic [AW-1:0]       rd1_i,
    input  logic [XLEN-1:0]     wd1_i,
    input  logic                iss_i,
    input  logic [AW-1:0]       iss_rd_i,
    output logic                any_busy_o
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    function automatic logic in_range(input logic [AW-1:0] idx);
        return int'(idx) < NREG;
    endfunction

    // Port 1 is written last so it wins a same-index conflict with port 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            if (we0_i && rd0_i != '0 && in_range(rd0_i)) begin
                regs[rd0_i] <= wd0_i;
            end
            if (we1_i && rd1_i != '0 && in_range(rd1_i)) begin
                regs[rd1_i] <= wd1_i;
            end
        end
    end

    // A new issue outranks a completing write so the new producer stays tracked.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (iss_i && iss_rd_i == AW'(r)) begin
                    busy[r] <= 1'b1;
                end else if ((we0_i && rd0_i == AW'(r)) || (we1_i && rd1_i == AW'(r))) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    assign any_busy_o = |busy;

    for (genvar k = 0; k < NRD; k++) begin : g_read
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] data;
        logic            busy_rd;

        assign idx = rs_i[k*AW +: AW];

        always_comb begin
            data    = '0;
            busy_rd = 1'b0;
            if (rst_ni && idx != '0 && in_range(idx)) begin
                data    = regs[idx];
                busy_rd = busy[idx];
                if (BYPASS != 0) begin
                    if (we1_i && rd1_i == idx) begin
                        data = wd1_i;
                    end else if (we0_i && rd0_i == idx) begin
                        data = wd0_i;
                    end
                    if (((we0_i && rd0_i == idx) || (we1_i && rd1_i == idx)) &&
                        !(iss_i && iss_rd_i == idx)) begin
                        busy_rd = 1'b0;
                    end
                end
            end
        end

        assign op_o[k*XLEN +: XLEN] = data;
        assign busy_o[k]            = busy_rd;
    end

endmodule
